// File: rtl/ysyx_exu_sys_pkg.sv
// Shared definitions for the EXU system-instruction sequencer: widths,
// SYS_* op encodings, CSR addresses, MSTATUS bit positions.
package ysyx_exu_sys_pkg;

  localparam int unsigned YSYX_W_WIDTH = 32;
  localparam int unsigned BIT_W        = YSYX_W_WIDTH;
  localparam int unsigned R_W          = 12;
  localparam int unsigned OP_W         = 3;

  // System op encodings from dispatch
  localparam logic [OP_W-1:0] SYS_CSRRW = 3'd1;
  localparam logic [OP_W-1:0] SYS_CSRRS = 3'd2;
  localparam logic [OP_W-1:0] SYS_CSRRC = 3'd3;
  localparam logic [OP_W-1:0] SYS_ECALL = 3'd4;
  localparam logic [OP_W-1:0] SYS_MRET  = 3'd5;

  // Machine-mode CSR addresses touched directly by this block
  localparam logic [R_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [R_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [R_W-1:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam logic [BIT_W-1:0] MCAUSE_ECALL = BIT_W'(11);

  // Instruction captured from dispatch on accept
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [BIT_W-1:0] pc;
    logic [R_W-1:0]   addr;
    logic [BIT_W-1:0] src;
    logic             src_zero;
  } sys_req_t;

  // MSTATUS after MRET: MIE <- MPIE, MPIE <- 1
  function automatic logic [BIT_W-1:0] mret_mstatus(input logic [BIT_W-1:0] old);
    logic [BIT_W-1:0] m;
    m               = old;
    m[MSTATUS_MIE]  = old[MSTATUS_MPIE];
    m[MSTATUS_MPIE] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ysyx_exu_sys_alu.sv
// Combinational CSR read-modify-write and PC-redirect computation.
module ysyx_exu_sys_alu
  import ysyx_exu_sys_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [BIT_W-1:0] old,
  input  logic [BIT_W-1:0] src,
  input  logic             src_zero,
  input  logic [BIT_W-1:0] pc,
  input  logic [BIT_W-1:0] mtvec,
  input  logic [BIT_W-1:0] mepc,
  output logic [BIT_W-1:0] wdata,
  output logic [BIT_W-1:0] wdata_add1,
  output logic             wen,
  output logic [BIT_W-1:0] rd,
  output logic [BIT_W-1:0] npc,
  output logic             redirect
);

  // Per-op write data, enable, rd result and next PC
  always_comb begin
    wdata      = '0;
    wdata_add1 = '0;
    wen        = 1'b0;
    rd         = '0;
    npc        = pc + BIT_W'(4);
    redirect   = 1'b0;
    case (op)
      SYS_CSRRW: begin
        wdata = src;
        wen   = 1'b1;
        rd    = old;
      end
      SYS_CSRRS: begin
        wdata = old | src;
        wen   = !src_zero;
        rd    = old;
      end
      SYS_CSRRC: begin
        wdata = old & ~src;
        wen   = !src_zero;
        rd    = old;
      end
      SYS_ECALL: begin
        wdata      = pc;
        wdata_add1 = MCAUSE_ECALL;
        wen        = 1'b1;
        npc        = mtvec;
        redirect   = 1'b1;
      end
      SYS_MRET: begin
        wdata    = mret_mstatus(old);
        wen      = 1'b1;
        npc      = mepc;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_exu_sys.sv
// EXU system-instruction sequencer: IDLE -> EXEC (one CSR-file strobe) -> RESP.
module ysyx_exu_sys
  import ysyx_exu_sys_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [BIT_W-1:0] in_pc,
  input  logic [R_W-1:0]   in_csr_addr,
  input  logic [BIT_W-1:0] in_src,
  input  logic             in_src_zero,
  input  logic [BIT_W-1:0] csr_rdata,
  input  logic [BIT_W-1:0] csr_mtvec,
  input  logic [BIT_W-1:0] csr_mepc,
  output logic             csr_exu_valid,
  output logic             csr_wen,
  output logic             csr_ecallen,
  output logic [R_W-1:0]   csr_waddr,
  output logic [BIT_W-1:0] csr_wdata,
  output logic [R_W-1:0]   csr_waddr_add1,
  output logic [BIT_W-1:0] csr_wdata_add1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT_W-1:0] out_rd_data,
  output logic             out_redirect,
  output logic [BIT_W-1:0] out_npc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t   state_q, state_d;
  sys_req_t req_q;
  logic     accept;

  logic [BIT_W-1:0] alu_wdata, alu_wdata_add1, alu_rd, alu_npc;
  logic             alu_wen, alu_redirect;

  ysyx_exu_sys_alu u_alu (
    .op         (req_q.op),
    .old        (csr_rdata),
    .src        (req_q.src),
    .src_zero   (req_q.src_zero),
    .pc         (req_q.pc),
    .mtvec      (csr_mtvec),
    .mepc       (csr_mepc),
    .wdata      (alu_wdata),
    .wdata_add1 (alu_wdata_add1),
    .wen        (alu_wen),
    .rd         (alu_rd),
    .npc        (alu_npc),
    .redirect   (alu_redirect)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshakes and CSR-file port (live only in EXEC so reset drops it at once)
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    csr_exu_valid  = 1'b0;
    csr_wen        = 1'b0;
    csr_ecallen    = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    csr_waddr_add1 = '0;
    csr_wdata_add1 = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        csr_exu_valid  = 1'b1;
        csr_wen        = alu_wen;
        csr_wdata      = alu_wdata;
        csr_wdata_add1 = alu_wdata_add1;
        case (req_q.op)
          SYS_CSRRW, SYS_CSRRS, SYS_CSRRC: csr_waddr = req_q.addr;
          SYS_ECALL: begin
            csr_waddr      = CSR_MEPC;
            csr_waddr_add1 = CSR_MCAUSE;
            csr_ecallen    = 1'b1;
          end
          SYS_MRET: csr_waddr = CSR_MSTATUS;
          default: ;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction capture on accept; result capture at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= '0;
      out_rd_data  <= '0;
      out_npc      <= '0;
      out_redirect <= 1'b0;
    end else begin
      if (accept) begin
        req_q.op       <= in_op;
        req_q.pc       <= in_pc;
        req_q.addr     <= in_csr_addr;
        req_q.src      <= in_src;
        req_q.src_zero <= in_src_zero;
      end
      if (state_q == S_EXEC) begin
        out_rd_data  <= alu_rd;
        out_npc      <= alu_npc;
        out_redirect <= alu_redirect;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_exu_sys.sv
// Directed self-checking bench for ysyx_exu_sys.
module tb_ysyx_exu_sys;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_pc, in_src;
  logic [11:0] in_csr_addr;
  logic        in_src_zero;
  logic [31:0] csr_rdata, csr_mtvec, csr_mepc;
  logic        csr_exu_valid, csr_wen, csr_ecallen;
  logic [11:0] csr_waddr, csr_waddr_add1;
  logic [31:0] csr_wdata, csr_wdata_add1;
  logic        out_valid, out_ready, out_redirect;
  logic [31:0] out_rd_data, out_npc;

  int checks = 0;
  int errors = 0;

  ysyx_exu_sys dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
    .in_csr_addr(in_csr_addr), .in_src(in_src), .in_src_zero(in_src_zero),
    .csr_rdata(csr_rdata), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_exu_valid(csr_exu_valid), .csr_wen(csr_wen), .csr_ecallen(csr_ecallen),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_waddr_add1(csr_waddr_add1), .csr_wdata_add1(csr_wdata_add1),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data),
    .out_redirect(out_redirect), .out_npc(out_npc)
  );

  always #5 clk = ~clk;

  // Offer one instruction for one cycle; returns at the falling edge inside EXEC
  task automatic issue(input logic [2:0] op, input logic [31:0] pc,
                       input logic [11:0] addr, input logic [31:0] src, input logic zero);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_csr_addr = addr; in_src = src; in_src_zero = zero;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Handshake the pending result; returns at a falling edge in IDLE
  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b want 0", out_redirect); end
    checks++; if (out_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", out_rd_data); end
    checks++; if (out_npc !== 32'h0) begin errors++; $display("FAIL reset_npc got %h want 0", out_npc); end
    checks++; if ({csr_exu_valid, csr_wen, csr_ecallen} !== 3'b000) begin errors++; $display("FAIL reset_csr_ctl got %b want 000", {csr_exu_valid, csr_wen, csr_ecallen}); end
    checks++; if ({csr_waddr, csr_waddr_add1} !== 24'h0) begin errors++; $display("FAIL reset_csr_addr got %h want 0", {csr_waddr, csr_waddr_add1}); end
  endtask

  task automatic test_csrrw();
    csr_rdata = 32'h0;
    issue(3'd1, 32'h8000_0000, 12'h305, 32'h8000_0100, 1'b0);
    checks++; if (csr_exu_valid !== 1'b1) begin errors++; $display("FAIL rw_exu_valid got %b want 1", csr_exu_valid); end
    checks++; if (csr_wen !== 1'b1) begin errors++; $display("FAIL rw_wen got %b want 1", csr_wen); end
    checks++; if (csr_waddr !== 12'h305) begin errors++; $display("FAIL rw_waddr got %h want 305", csr_waddr); end
    checks++; if (csr_wdata !== 32'h8000_0100) begin errors++; $display("FAIL rw_wdata got %h want 80000100", csr_wdata); end
    checks++; if ({csr_ecallen, csr_waddr_add1} !== 13'h0) begin errors++; $display("FAIL rw_add1 got %h want 0", {csr_ecallen, csr_waddr_add1}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rw_in_ready_exec got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_early_valid got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rw_out_valid got %b want 1", out_valid); end
    checks++; if (out_rd_data !== 32'h0) begin errors++; $display("FAIL rw_rd got %h want 0", out_rd_data); end
    checks++; if (out_npc !== 32'h8000_0004) begin errors++; $display("FAIL rw_npc got %h want 80000004", out_npc); end
    checks++; if (out_redirect !== 1'b0) begin errors++; $display("FAIL rw_redirect got %b want 0", out_redirect); end
    checks++; if (csr_exu_valid !== 1'b0) begin errors++; $display("FAIL rw_strobe_in_resp got %b want 0", csr_exu_valid); end
    retire();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rw_back_idle got %b want 1", in_ready); end
  endtask

  task automatic test_csrrs_csrrc();
    csr_rdata = 32'h1800;
    issue(3'd2, 32'h8000_0010, 12'h300, 32'h8, 1'b0);
    checks++; if (csr_wen !== 1'b1) begin errors++; $display("FAIL rs_wen got %b want 1", csr_wen); end
    checks++; if (csr_wdata !== 32'h1808) begin errors++; $display("FAIL rs_wdata got %h want 1808", csr_wdata); end
    @(negedge clk);
    checks++; if (out_rd_data !== 32'h1800) begin errors++; $display("FAIL rs_rd got %h want 1800", out_rd_data); end
    checks++; if (out_npc !== 32'h8000_0014) begin errors++; $display("FAIL rs_npc got %h want 80000014", out_npc); end
    retire();
    issue(3'd2, 32'h8000_0014, 12'h300, 32'h0, 1'b1);
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL rs0_wen got %b want 0", csr_wen); end
    checks++; if (csr_exu_valid !== 1'b1) begin errors++; $display("FAIL rs0_exu_valid got %b want 1", csr_exu_valid); end
    @(negedge clk);
    checks++; if (out_rd_data !== 32'h1800) begin errors++; $display("FAIL rs0_rd got %h want 1800", out_rd_data); end
    retire();
    csr_rdata = 32'h0000_00FF;
    issue(3'd3, 32'h8000_0020, 12'h340, 32'h0000_000F, 1'b0);
    checks++; if (csr_wdata !== 32'h0000_00F0) begin errors++; $display("FAIL rc_wdata got %h want 000000f0", csr_wdata); end
    checks++; if (csr_waddr !== 12'h340) begin errors++; $display("FAIL rc_waddr got %h want 340", csr_waddr); end
    checks++; if (csr_wen !== 1'b1) begin errors++; $display("FAIL rc_wen got %b want 1", csr_wen); end
    @(negedge clk);
    checks++; if (out_rd_data !== 32'h0000_00FF) begin errors++; $display("FAIL rc_rd got %h want 000000ff", out_rd_data); end
    retire();
  endtask

  task automatic test_ecall();
    csr_rdata = 32'hDEAD_BEEF;
    csr_mtvec = 32'h8000_0200;
    issue(3'd4, 32'h8000_0040, 12'h000, 32'h0, 1'b1);
    checks++; if (csr_waddr !== 12'h341) begin errors++; $display("FAIL ecall_waddr got %h want 341", csr_waddr); end
    checks++; if (csr_wdata !== 32'h8000_0040) begin errors++; $display("FAIL ecall_wdata got %h want 80000040", csr_wdata); end
    checks++; if (csr_waddr_add1 !== 12'h342) begin errors++; $display("FAIL ecall_waddr1 got %h want 342", csr_waddr_add1); end
    checks++; if (csr_wdata_add1 !== 32'd11) begin errors++; $display("FAIL ecall_wdata1 got %h want 0000000b", csr_wdata_add1); end
    checks++; if ({csr_wen, csr_ecallen} !== 2'b11) begin errors++; $display("FAIL ecall_wen_ecallen got %b want 11", {csr_wen, csr_ecallen}); end
    @(negedge clk);
    csr_mtvec = 32'h1111_0000;
    checks++; if (out_redirect !== 1'b1) begin errors++; $display("FAIL ecall_redirect got %b want 1", out_redirect); end
    checks++; if (out_npc !== 32'h8000_0200) begin errors++; $display("FAIL ecall_npc got %h want 80000200", out_npc); end
    checks++; if (out_rd_data !== 32'h0) begin errors++; $display("FAIL ecall_rd got %h want 0", out_rd_data); end
    retire();
  endtask

  task automatic test_mret();
    csr_rdata = 32'h0000_0080;
    csr_mepc  = 32'h8000_0044;
    issue(3'd5, 32'h8000_0300, 12'h000, 32'h0, 1'b1);
    checks++; if (csr_waddr !== 12'h300) begin errors++; $display("FAIL mret_waddr got %h want 300", csr_waddr); end
    checks++; if (csr_wdata !== 32'h0000_0088) begin errors++; $display("FAIL mret_wdata got %h want 00000088", csr_wdata); end
    checks++; if (csr_waddr_add1 !== 12'h0) begin errors++; $display("FAIL mret_waddr1 got %h want 0", csr_waddr_add1); end
    checks++; if ({csr_wen, csr_ecallen} !== 2'b10) begin errors++; $display("FAIL mret_wen_ecallen got %b want 10", {csr_wen, csr_ecallen}); end
    @(negedge clk);
    checks++; if (out_npc !== 32'h8000_0044) begin errors++; $display("FAIL mret_npc got %h want 80000044", out_npc); end
    checks++; if (out_redirect !== 1'b1) begin errors++; $display("FAIL mret_redirect got %b want 1", out_redirect); end
    checks++; if (out_rd_data !== 32'h0) begin errors++; $display("FAIL mret_rd got %h want 0", out_rd_data); end
    retire();
  endtask

  task automatic test_illegal();
    csr_rdata = 32'h1234_5678;
    issue(3'd7, 32'h8000_0050, 12'h305, 32'hFFFF_FFFF, 1'b0);
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL ill_wen got %b want 0", csr_wen); end
    checks++; if (csr_exu_valid !== 1'b1) begin errors++; $display("FAIL ill_exu_valid got %b want 1", csr_exu_valid); end
    @(negedge clk);
    checks++; if (out_rd_data !== 32'h0) begin errors++; $display("FAIL ill_rd got %h want 0", out_rd_data); end
    checks++; if (out_npc !== 32'h8000_0054) begin errors++; $display("FAIL ill_npc got %h want 80000054", out_npc); end
    checks++; if (out_redirect !== 1'b0) begin errors++; $display("FAIL ill_redirect got %b want 0", out_redirect); end
    retire();
  endtask

  task automatic test_backpressure();
    int pulses;
    csr_rdata = 32'hAAAA_0000;
    issue(3'd1, 32'h8000_0060, 12'h340, 32'h5555, 1'b0);
    pulses = csr_exu_valid ? 1 : 0;
    in_valid = 1'b1; in_op = 3'd1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (csr_exu_valid) pulses++;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_rd_data !== 32'hAAAA_0000) begin errors++; $display("FAIL bp_rd[%0d] got %h want aaaa0000", i, out_rd_data); end
      checks++; if (out_npc !== 32'h8000_0064) begin errors++; $display("FAIL bp_npc[%0d] got %h want 80000064", i, out_npc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bp_strobe_pulses got %0d want 1", pulses); end
    in_valid = 1'b0;
    retire();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    csr_rdata = 32'h0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd1; in_pc = 32'h8000_0070; in_csr_addr = 12'h340; in_src = 32'h1; in_src_zero = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++; if (csr_exu_valid !== (i % 3 == 0)) begin errors++; $display("FAIL b2b_strobe[%0d] got %b want %b", i, csr_exu_valid, (i % 3 == 0)); end
      checks++; if (out_valid !== (i % 3 == 1)) begin errors++; $display("FAIL b2b_out_valid[%0d] got %b want %b", i, out_valid, (i % 3 == 1)); end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_exec();
    issue(3'd4, 32'h8000_0080, 12'h000, 32'h0, 1'b1);
    checks++; if (csr_exu_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_strobe got %b want 1", csr_exu_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({csr_exu_valid, csr_wen, csr_ecallen} !== 3'b000) begin errors++; $display("FAIL rst_csr_ctl got %b want 000", {csr_exu_valid, csr_wen, csr_ecallen}); end
    checks++; if ({csr_waddr, csr_waddr_add1} !== 24'h0) begin errors++; $display("FAIL rst_csr_addr got %h want 0", {csr_waddr, csr_waddr_add1}); end
    checks++; if ({csr_wdata, csr_wdata_add1} !== 64'h0) begin errors++; $display("FAIL rst_csr_data got %h want 0", {csr_wdata, csr_wdata_add1}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b want 0", out_redirect); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_op = '0; in_pc = '0; in_csr_addr = '0; in_src = '0; in_src_zero = 1'b0;
    csr_rdata = '0; csr_mtvec = '0; csr_mepc = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_csrrw();
    test_csrrs_csrrc();
    test_ecall();
    test_mret();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
